// File: rtl/player_bullet_pool.sv
// Player bullet pool.
// Owns a small set of bullet slots that are fed by the paddle stage.
// A fire edge arms a single pending shot. On each frame pulse the pool
// retires killed slots, moves the live bullets upward, retires bullets that
// have left the top of the screen, and then launches the pending shot into
// the lowest free slot once the cooldown has expired. A registered renderer
// reports whether the current hpos/vpos falls on any live bullet, using the
// same pixel/active format as the paddle.

module player_bullet_pool #(
    parameter int          VRES            = 480,
    parameter int          PADDLE_H        = 16,
    parameter int          MAX_BULLETS     = 4,
    parameter int          BULLET_W        = 2,
    parameter int          BULLET_H        = 8,
    parameter int          BULLET_SPEED    = 6,
    parameter int          COOLDOWN_FRAMES = 10,
    parameter int          SPAWN_Y         = VRES - PADDLE_H - BULLET_H,
    parameter logic [23:0] BULLET_RGB      = 24'hFFFF00
) (
    input  logic                          pixel_clk,
    input  logic                          rst_n,
    input  logic                          fsync,
    input  logic                          fire,
    input  logic signed [11:0]            paddle_center_x,
    input  logic signed [11:0]            hpos,
    input  logic signed [11:0]            vpos,
    input  logic [MAX_BULLETS-1:0]        kill,
    output logic [7:0]                    pixel [0:2],
    output logic                          active,
    output logic [MAX_BULLETS-1:0]        bullet_valid,
    output logic [12*MAX_BULLETS-1:0]     bullet_x,
    output logic [12*MAX_BULLETS-1:0]     bullet_y
);

    // Cooldown counter must hold COOLDOWN_FRAMES itself.
    localparam int CD_W  = $clog2(COOLDOWN_FRAMES + 1);
    localparam int IDX_W = (MAX_BULLETS > 1) ? $clog2(MAX_BULLETS) : 1;

    // Position arithmetic is done one bit wider than the stored coordinates
    // so that moving a bullet near the bottom of the signed range, or adding
    // the bullet extent, can never wrap.
    localparam logic signed [12:0] SPEED13   = 13'(BULLET_SPEED);
    localparam logic signed [12:0] H13       = 13'(BULLET_H);
    localparam logic signed [12:0] W13       = 13'(BULLET_W);
    localparam logic signed [11:0] SPAWN_Y12 = 12'(SPAWN_Y);
    localparam logic signed [11:0] HALF_W12  = 12'(BULLET_W / 2);
    localparam logic [CD_W-1:0]    CD_RELOAD = CD_W'(COOLDOWN_FRAMES);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                    r_fire_d;
    logic                    r_pending;
    logic [CD_W-1:0]         r_cooldown;
    logic [MAX_BULLETS-1:0]  r_valid;
    logic signed [11:0]      r_x [0:MAX_BULLETS-1];
    logic signed [11:0]      r_y [0:MAX_BULLETS-1];
    logic                    r_active;
    logic [23:0]             r_rgb;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                    w_fire_edge;
    logic [MAX_BULLETS-1:0]  w_alive;     // valid after kill
    logic [MAX_BULLETS-1:0]  w_retire;    // would leave the screen top this frame
    logic [MAX_BULLETS-1:0]  w_moved;     // valid after kill and move
    logic signed [12:0]      w_y_next [0:MAX_BULLETS-1];
    logic [MAX_BULLETS-1:0]  w_free;
    logic                    w_have_free;
    logic [IDX_W-1:0]        w_spawn_idx;
    logic                    w_cd_zero;
    logic                    w_spawn;
    logic signed [11:0]      w_spawn_x;

    logic signed [12:0]      w_h13;
    logic signed [12:0]      w_v13;
    logic signed [12:0]      w_x13 [0:MAX_BULLETS-1];
    logic signed [12:0]      w_y13 [0:MAX_BULLETS-1];
    logic [MAX_BULLETS-1:0]  w_hit_vec;
    logic                    w_hit;

    // Fire edge detect against the registered button level.
    assign w_fire_edge = fire & ~r_fire_d;

    // Kill first, then move; a killed slot is never moved.
    always_comb begin
        w_alive = r_valid & ~kill;
        w_retire = '0;
        w_moved = '0;
        for (int i = 0; i < MAX_BULLETS; i++) begin
            w_y_next[i] = $signed({r_y[i][11], r_y[i]}) - SPEED13;
            w_retire[i] = ((w_y_next[i] + H13) <= 13'sd0);
            w_moved[i]  = w_alive[i] & ~w_retire[i];
        end
    end

    // Lowest free slot after kill and move; scan high to low so the lowest wins.
    always_comb begin
        w_free = ~w_moved;
        w_have_free = |w_free;
        w_spawn_idx = '0;
        for (int i = MAX_BULLETS - 1; i >= 0; i--) begin
            if (w_free[i]) begin
                w_spawn_idx = IDX_W'(i);
            end
        end
    end

    // Spawn decision uses the registered pending flag and pre-decrement cooldown.
    assign w_cd_zero = (r_cooldown == '0);
    assign w_spawn   = fsync & r_pending & w_cd_zero & w_have_free;
    assign w_spawn_x = paddle_center_x - HALF_W12;

    // ------------------------------------------------------------------
    // Fire capture, pending shot and cooldown
    // ------------------------------------------------------------------
    // Registers the button, arms one pending shot per edge, runs the cooldown.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fire_d   <= 1'b0;
            r_pending  <= 1'b0;
            r_cooldown <= '0;
        end else begin
            r_fire_d <= fire;

            // An edge while a shot is already pending is simply dropped.
            if (w_spawn) begin
                r_pending <= 1'b0;
            end else if (w_fire_edge) begin
                r_pending <= 1'b1;
            end

            if (fsync) begin
                if (w_spawn) begin
                    r_cooldown <= CD_RELOAD;
                end else if (!w_cd_zero) begin
                    r_cooldown <= r_cooldown - 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Bullet slots
    // ------------------------------------------------------------------
    // Frame update (kill, move, spawn) on fsync; otherwise only kills apply.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < MAX_BULLETS; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
        end else if (fsync) begin
            for (int i = 0; i < MAX_BULLETS; i++) begin
                r_valid[i] <= w_moved[i];
                if (w_moved[i]) begin
                    r_y[i] <= w_y_next[i][11:0];
                end
            end
            // The spawn slot is free after kill/move, so these writes win and
            // the new bullet does not move in its spawn frame.
            if (w_spawn) begin
                r_valid[w_spawn_idx] <= 1'b1;
                r_x[w_spawn_idx]     <= w_spawn_x;
                r_y[w_spawn_idx]     <= SPAWN_Y12;
            end
        end else begin
            r_valid <= w_alive;
        end
    end

    // ------------------------------------------------------------------
    // Renderer
    // ------------------------------------------------------------------
    assign w_h13 = $signed({hpos[11], hpos});
    assign w_v13 = $signed({vpos[11], vpos});

    // Per-slot signed rectangle test against the current beam position.
    always_comb begin
        w_hit_vec = '0;
        for (int i = 0; i < MAX_BULLETS; i++) begin
            w_x13[i] = $signed({r_x[i][11], r_x[i]});
            w_y13[i] = $signed({r_y[i][11], r_y[i]});
            w_hit_vec[i] = r_valid[i]
                         & (w_h13 >= w_x13[i]) & (w_h13 < (w_x13[i] + W13))
                         & (w_v13 >= w_y13[i]) & (w_v13 < (w_y13[i] + H13));
        end
    end

    assign w_hit = |w_hit_vec;

    // One-cycle registered pixel output; overlaps look the same as one bullet.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_rgb    <= '0;
        end else begin
            r_active <= w_hit;
            r_rgb    <= w_hit ? BULLET_RGB : 24'h000000;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign active       = r_active;
    assign pixel[2]     = r_rgb[23:16];
    assign pixel[1]     = r_rgb[15:8];
    assign pixel[0]     = r_rgb[7:0];
    assign bullet_valid = r_valid;

    // Pack per-slot coordinates, slot i at bits [12i+11:12i].
    always_comb begin
        bullet_x = '0;
        bullet_y = '0;
        for (int i = 0; i < MAX_BULLETS; i++) begin
            bullet_x[12*i +: 12] = r_x[i];
            bullet_y[12*i +: 12] = r_y[i];
        end
    end

endmodule

// File: tb/tb_player_bullet_pool.sv
// Directed bench for player_bullet_pool with default parameters
// (SPAWN_Y = 480 - 16 - 8 = 456, speed 6, cooldown 10, 2x8 bullets).

module tb_player_bullet_pool;

  logic              clk;
  logic              rst_n;
  logic              fsync;
  logic              fire;
  logic signed [11:0] paddle_center_x;
  logic signed [11:0] hpos;
  logic signed [11:0] vpos;
  logic [3:0]        kill;
  logic [7:0]        pixel [0:2];
  logic              active;
  logic [3:0]        bullet_valid;
  logic [47:0]       bullet_x;
  logic [47:0]       bullet_y;

  int n_checks;
  int n_errors;

  localparam logic [11:0] SPAWN_Y = 12'd456;

  player_bullet_pool dut (
    .pixel_clk       (clk),
    .rst_n           (rst_n),
    .fsync           (fsync),
    .fire            (fire),
    .paddle_center_x (paddle_center_x),
    .hpos            (hpos),
    .vpos            (vpos),
    .kill            (kill),
    .pixel           (pixel),
    .active          (active),
    .bullet_valid    (bullet_valid),
    .bullet_x        (bullet_x),
    .bullet_y        (bullet_y)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change and outputs are sampled 1 ns after posedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    tick();
  endtask

  task automatic fire_pulse();
    fire = 1'b1;
    tick();
    fire = 1'b0;
    tick();
  endtask

  function automatic logic [11:0] bx(input int i);
    return bullet_x[12*i +: 12];
  endfunction

  function automatic logic [11:0] by(input int i);
    return bullet_y[12*i +: 12];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    fsync = 1'b0;
    fire = 1'b0;
    paddle_center_x = 12'sd320;
    hpos = '0;
    vpos = '0;
    kill = '0;

    // reset state
    tick(); tick(); tick();
    check("rst_valid", 32'(bullet_valid), 32'h0);
    check("rst_x", 32'(bullet_x[31:0]), 32'h0);
    check("rst_y", 32'(bullet_y[31:0]), 32'h0);
    check("rst_active", 32'(active), 32'h0);
    check("rst_pixel", 32'({pixel[2], pixel[1], pixel[0]}), 32'h0);
    rst_n = 1'b1;
    tick();

    // single shot
    fire_pulse();
    frame();
    check("shot_valid", 32'(bullet_valid), 32'h1);
    check("shot_x0", 32'(bx(0)), 32'd319);
    check("shot_y0", 32'(by(0)), 32'(SPAWN_Y));
    frame();
    check("move_y0", 32'(by(0)), 32'd450);

    // render: bullet 0 covers x 319..320, y 450..457
    hpos = 12'sd320; vpos = 12'sd457;
    tick();
    check("rend_hit_active", 32'(active), 32'h1);
    check("rend_hit_pixel", 32'({pixel[2], pixel[1], pixel[0]}), 32'hFFFF00);
    hpos = 12'sd321;
    tick();
    check("rend_right_active", 32'(active), 32'h0);
    check("rend_right_pixel", 32'({pixel[2], pixel[1], pixel[0]}), 32'h0);
    hpos = 12'sd319; vpos = 12'sd450;
    tick();
    check("rend_corner_active", 32'(active), 32'h1);
    hpos = 12'sd320; vpos = 12'sd458;
    tick();
    check("rend_below_active", 32'(active), 32'h0);
    hpos = '0; vpos = '0;

    // exit top: 74 frames bring y from 450 to 6
    for (int i = 0; i < 74; i++) frame();
    check("top_y6", 32'(by(0)), 32'd6);
    frame();
    check("top_y0", 32'(by(0)), 32'd0);
    check("top_y0_valid", 32'(bullet_valid), 32'h1);
    frame();
    check("top_yneg6", 32'(by(0)), 32'hFFA);
    check("top_yneg6_valid", 32'(bullet_valid), 32'h1);
    frame();
    check("top_retired", 32'(bullet_valid), 32'h0);

    // cooldown: fire edge before every frame for 12 frames
    fire_pulse();
    frame();
    check("cd_f0_valid", 32'(bullet_valid), 32'h1);
    for (int f = 1; f <= 10; f++) begin
      fire_pulse();
      frame();
    end
    check("cd_f10_valid", 32'(bullet_valid), 32'h1);
    fire_pulse();
    frame();
    check("cd_f11_valid", 32'(bullet_valid), 32'h3);
    check("cd_f11_y1", 32'(by(1)), 32'(SPAWN_Y));
    check("cd_f11_y0", 32'(by(0)), 32'd390);

    // hold fire high for 50 frames: only one more spawn (slot 2, frame 11)
    fire = 1'b1;
    tick();
    for (int f = 0; f < 50; f++) frame();
    fire = 1'b0;
    tick();
    check("hold_valid", 32'(bullet_valid), 32'h7);
    check("hold_y2", 32'(by(2)), 32'd222);
    check("hold_y0", 32'(by(0)), 32'd90);

    // pool full: slot 3 spawns, then a further shot is blocked
    fire_pulse();
    frame();
    check("full_valid", 32'(bullet_valid), 32'hF);
    check("full_y0", 32'(by(0)), 32'd84);
    fire_pulse();
    for (int f = 0; f < 11; f++) frame();
    check("full_blocked", 32'(bullet_valid), 32'hF);
    check("full_blocked_y0", 32'(by(0)), 32'd18);
    kill = 4'b0100;
    tick();
    kill = '0;
    check("kill_mid_frame", 32'(bullet_valid), 32'hB);
    tick();
    paddle_center_x = 12'sd100;
    frame();
    check("refill_valid", 32'(bullet_valid), 32'hF);
    check("refill_x2", 32'(bx(2)), 32'd99);
    check("refill_y2", 32'(by(2)), 32'(SPAWN_Y));

    // kill has priority over movement on a frame pulse
    kill = 4'b0001;
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    kill = '0;
    tick();
    check("kill_fsync_valid", 32'(bullet_valid), 32'hE);

    // reset mid-operation with a pending shot
    fire_pulse();
    hpos = 12'sd99; vpos = 12'sd450;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bullet_valid), 32'h0);
    tick(); tick(); tick();
    check("mid_rst_valid", 32'(bullet_valid), 32'h0);
    check("mid_rst_x", 32'(bullet_x[31:0]), 32'h0);
    check("mid_rst_y", 32'(bullet_y[31:0]), 32'h0);
    check("mid_rst_active", 32'(active), 32'h0);
    check("mid_rst_pixel", 32'({pixel[2], pixel[1], pixel[0]}), 32'h0);
    rst_n = 1'b1;
    tick();
    frame();
    check("post_rst_valid", 32'(bullet_valid), 32'h0);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
